// File: rtl/ahb_to_apb_bridge_if.sv
// Bus bundle for the AHB-Lite to APB4 bridge.
// The slave modport is the bridge's view; the master modport is the view of
// the environment that drives AHB requests and answers APB accesses.
interface ahb_to_apb_bridge_if #(
  parameter int ADDRWIDTH = 16
);
  logic                 HSEL;
  logic [ADDRWIDTH-1:0] HADDR;
  logic [1:0]           HTRANS;
  logic [2:0]           HSIZE;
  logic [3:0]           HPROT;
  logic                 HWRITE;
  logic                 HREADY;
  logic [31:0]          HWDATA;
  logic                 HREADYOUT;
  logic [31:0]          HRDATA;
  logic                 HRESP;
  logic [ADDRWIDTH-1:0] PADDR;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [3:0]           PSTRB;
  logic [2:0]           PPROT;
  logic [31:0]          PWDATA;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HREADY, HWDATA,
    input  PRDATA, PREADY, PSLVERR,
    output HREADYOUT, HRDATA, HRESP,
    output PADDR, PSEL, PENABLE, PWRITE, PSTRB, PPROT, PWDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HREADY, HWDATA,
    output PRDATA, PREADY, PSLVERR,
    input  HREADYOUT, HRDATA, HRESP,
    input  PADDR, PSEL, PENABLE, PWRITE, PSTRB, PPROT, PWDATA
  );
endinterface

// File: rtl/ahb_to_apb_bridge.sv
// Single-clock AHB-Lite slave to APB4 master bridge. Every accepted AHB
// transfer becomes one APB SETUP/ACCESS sequence; all outputs are registered.
// Optional build macro APB_TIMEOUT_EN bounds the ACCESS-phase wait to
// TIMEOUT_CYCLES cycles and turns an expired wait into an ERROR response.
//
// state  | meaning
// IDLE   | ready, HREADYOUT=1, no APB activity
// WDATA  | AHB write data phase, HWDATA captured into PWDATA
// SETUP  | APB setup phase, PSEL=1 PENABLE=0
// ACCESS | APB access phase, PSEL=1 PENABLE=1, waiting for PREADY
// ERR1   | first ERROR cycle, HRESP=1 HREADYOUT=0
// ERR2   | second ERROR cycle, HRESP=1 HREADYOUT=1, may accept next transfer
module ahb_to_apb_bridge #(
  parameter int ADDRWIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                HCLK,
  input logic                HRESETn,
  ahb_to_apb_bridge_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WDATA  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_ERR1   = 3'd4;
  localparam logic [2:0] ST_ERR2   = 3'd5;

  logic [2:0]           state;
  logic                 hreadyout_q;
  logic                 hresp_q;
  logic [31:0]          hrdata_q;
  logic [ADDRWIDTH-1:0] paddr_q;
  logic                 psel_q;
  logic                 penable_q;
  logic                 pwrite_q;
  logic [3:0]           pstrb_q;
  logic [2:0]           pprot_q;
  logic [31:0]          pwdata_q;

  logic                 accept;
  logic                 illegal;
  logic [3:0]           strb_nxt;
  logic [ADDRWIDTH-1:0] haddr;
  logic                 timeout_hit;

  // HPROT[3:2] (cacheable/bufferable) has no APB4 counterpart.
  logic unused_hprot;
  assign unused_hprot = ^bus.HPROT[3:2];

  assign haddr  = bus.HADDR;
  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY & hreadyout_q &
                  ((state == ST_IDLE) | (state == ST_ERR2));

  // Size/alignment decode and write strobes for the transfer being offered
  always_comb begin
    illegal  = (bus.HSIZE > 3'd2) ||
               ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
               ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
    strb_nxt = 4'b0000;
    if (bus.HWRITE) begin
      case (bus.HSIZE)
        3'd0:    strb_nxt = 4'b0001 << bus.HADDR[1:0];
        3'd1:    strb_nxt = bus.HADDR[1] ? 4'b1100 : 4'b0011;
        default: strb_nxt = 4'b1111;
      endcase
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // Terminal count is one below the limit so the error is taken on the edge
  // that would make the count equal TIMEOUT_CYCLES.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles spent waiting for PREADY, cleared on the way into ACCESS
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ST_ACCESS) && !bus.PREADY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Bridge FSM; every output register is loaded with its next-state value
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          state       <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          if (accept) begin
            hreadyout_q <= 1'b0;
            if (illegal) begin
              state   <= ST_ERR1;
              hresp_q <= 1'b1;
            end else begin
              paddr_q  <= haddr;
              pwrite_q <= bus.HWRITE;
              pstrb_q  <= strb_nxt;
              pprot_q  <= {~bus.HPROT[0], 1'b1, bus.HPROT[1]};
              if (bus.HWRITE) begin
                state <= ST_WDATA;
              end else begin
                state  <= ST_SETUP;
                psel_q <= 1'b1;
              end
            end
          end
        end
        ST_WDATA: begin
          pwdata_q <= bus.HWDATA;
          psel_q   <= 1'b1;
          state    <= ST_SETUP;
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (bus.PSLVERR) begin
              state   <= ST_ERR1;
              hresp_q <= 1'b1;
            end else begin
              state       <= ST_IDLE;
              hreadyout_q <= 1'b1;
              if (!pwrite_q) hrdata_q <= bus.PRDATA;
            end
          end else if (timeout_hit) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= ST_ERR1;
            hresp_q   <= 1'b1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PPROT     = pprot_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Self-checking bench for ahb_to_apb_bridge: directed plan items plus
// randomized transfers checked cycle by cycle against a timeline model.
module tb_ahb_to_apb_bridge;
  localparam int AW = 16;
`ifdef APB_TIMEOUT_EN
  localparam int TO        = 4;
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam int TO        = 255;
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_hrdata = '0;

  ahb_to_apb_bridge_if #(.ADDRWIDTH(AW)) bus ();

  ahb_to_apb_bridge #(.ADDRWIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  // Transfer is illegal when larger than a word or not naturally aligned.
  function automatic bit model_illegal(input int a, input int sz);
    if (sz > 2) return 1'b1;
    return (a % (1 << sz)) != 0;
  endfunction

  // Write strobes: (bytes-in-transfer) ones, shifted to the byte lane.
  function automatic logic [3:0] model_strb(input int a, input int sz, input bit wr);
    int nb;
    if (!wr) return 4'b0000;
    nb = 1 << sz;
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  // PPROT: [2]=instruction (HPROT[0]=0), [1]=non-secure, [0]=privileged.
  function automatic logic [2:0] model_pprot(input logic [3:0] p);
    int v;
    v = 2;
    if (!p[0]) v += 4;
    if (p[1]) v += 1;
    return 3'(v);
  endfunction

  // Runs one AHB transfer and checks each cycle after the accept edge.
  // Returns at the negedge of the final response cycle, with HREADYOUT=1,
  // so a following call is accepted back-to-back.
  task automatic run_xfer(input string name, input logic [AW-1:0] addr, input logic [2:0] sz,
                          input bit wr, input logic [3:0] prot, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int wait_n, input bit slverr);
    bit          illegal, err, err_resp, exp_psel, exp_pen, exp_rdy, exp_resp;
    int          s, w, done_k, total, comp_k;
    logic [3:0]  estrb;
    logic [2:0]  eprot;
    illegal = model_illegal(int'(addr), int'(sz));
    estrb   = model_strb(int'(addr), int'(sz), wr);
    eprot   = model_pprot(prot);
    s       = wr ? 2 : 1;
    w       = wait_n;
    err     = slverr;
    if (!illegal && TIMEOUT_ON && wait_n >= TO) begin
      w   = TO - 1;
      err = 1'b1;
    end
    err_resp = illegal || err;
    done_k   = illegal ? 1 : s + 2 + w;
    total    = err_resp ? done_k + 1 : done_k;
    comp_k   = s + 1 + wait_n;
    if (!err_resp && !wr) model_hrdata = rdata;

    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HSIZE  = sz;
    bus.HWRITE = wr;
    bus.HPROT  = prot;
    bus.HREADY = 1'b1;
    @(posedge HCLK);
    #1;
    bus.HSEL   = 1'($urandom_range(0, 1));
    bus.HTRANS = 2'($urandom_range(0, 1));
    bus.HADDR  = AW'($urandom);
    bus.HWDATA = wdata;
    for (int k = 1; k <= total; k++) begin
      if (k > 1) bus.HWDATA = $urandom;
      if (!illegal && k == comp_k) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = slverr;
        bus.PRDATA  = rdata;
      end else begin
        bus.PREADY  = (!illegal && k >= s + 1 && k < comp_k) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA  = $urandom;
      end
      @(negedge HCLK);
      exp_psel = !illegal && k >= s && k <= s + 1 + w;
      exp_pen  = !illegal && k >= s + 1 && k <= s + 1 + w;
      exp_rdy  = (k == total);
      exp_resp = err_resp && k >= done_k;
      n_checks++;
      if (bus.PSEL !== exp_psel) begin
        n_fail++;
        $display("FAIL %s k=%0d PSEL: got %b expected %b", name, k, bus.PSEL, exp_psel);
      end
      n_checks++;
      if (bus.PENABLE !== exp_pen) begin
        n_fail++;
        $display("FAIL %s k=%0d PENABLE: got %b expected %b", name, k, bus.PENABLE, exp_pen);
      end
      n_checks++;
      if (bus.HREADYOUT !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s k=%0d HREADYOUT: got %b expected %b", name, k, bus.HREADYOUT, exp_rdy);
      end
      n_checks++;
      if (bus.HRESP !== exp_resp) begin
        n_fail++;
        $display("FAIL %s k=%0d HRESP: got %b expected %b", name, k, bus.HRESP, exp_resp);
      end
      if (exp_psel) begin
        n_checks++;
        if (bus.PADDR !== addr) begin
          n_fail++;
          $display("FAIL %s k=%0d PADDR: got %h expected %h", name, k, bus.PADDR, addr);
        end
        n_checks++;
        if (bus.PWRITE !== wr) begin
          n_fail++;
          $display("FAIL %s k=%0d PWRITE: got %b expected %b", name, k, bus.PWRITE, wr);
        end
        n_checks++;
        if (bus.PSTRB !== estrb) begin
          n_fail++;
          $display("FAIL %s k=%0d PSTRB: got %b expected %b", name, k, bus.PSTRB, estrb);
        end
        n_checks++;
        if (bus.PPROT !== eprot) begin
          n_fail++;
          $display("FAIL %s k=%0d PPROT: got %b expected %b", name, k, bus.PPROT, eprot);
        end
        if (wr) begin
          n_checks++;
          if (bus.PWDATA !== wdata) begin
            n_fail++;
            $display("FAIL %s k=%0d PWDATA: got %h expected %h", name, k, bus.PWDATA, wdata);
          end
        end
      end
      if (k == total) begin
        n_checks++;
        if (bus.HRDATA !== model_hrdata) begin
          n_fail++;
          $display("FAIL %s k=%0d HRDATA: got %h expected %h", name, k, bus.HRDATA, model_hrdata);
        end
      end
      if (k < total) begin
        @(posedge HCLK);
        #1;
      end
    end
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
  endtask

  // Non-accepting bus cycles: deselected, IDLE/BUSY, or HREADY low.
  task automatic test_idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.HADDR  = AW'($urandom);
      bus.HWRITE = 1'($urandom_range(0, 1));
      bus.HSIZE  = 3'($urandom_range(0, 2));
      bus.HREADY = 1'b1;
      case ($urandom_range(0, 3))
        0: begin bus.HSEL = 1'b0; bus.HTRANS = 2'b10; end
        1: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b00; end
        2: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b01; end
        default: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HREADY = 1'b0; end
      endcase
      @(posedge HCLK);
      @(negedge HCLK);
      n_checks++;
      if (bus.PSEL !== 1'b0 || bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
        n_fail++;
        $display("FAIL idle cycle %0d: PSEL=%b HREADYOUT=%b HRESP=%b expected 0/1/0",
                 i, bus.PSEL, bus.HREADYOUT, bus.HRESP);
      end
    end
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HREADY = 1'b1;
  endtask

  task automatic test_reset();
    #2 HRESETn = 1'b0;
    #1;
    n_checks++;
    if ({bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.PWRITE} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset ctrl: got %b expected 10000",
               {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.PWRITE});
    end
    n_checks++;
    if ({bus.HRDATA, bus.PWDATA, bus.PADDR, bus.PSTRB, bus.PPROT} !== '0) begin
      n_fail++;
      $display("FAIL reset data: HRDATA=%h PWDATA=%h PADDR=%h PSTRB=%b PPROT=%b expected all 0",
               bus.HRDATA, bus.PWDATA, bus.PADDR, bus.PSTRB, bus.PPROT);
    end
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    model_hrdata = '0;
    test_idle(2);
  endtask

  task automatic test_word_read();
    run_xfer("word_read", 16'h0104, 3'd2, 1'b0, 4'b0011, 32'h0, 32'hDEADBEEF, 0, 1'b0);
  endtask

  task automatic test_byte_write();
    run_xfer("byte_write", 16'h0203, 3'd0, 1'b1, 4'b0001, 32'hAA000000, 32'h0, 0, 1'b0);
  endtask

  task automatic test_half_wait();
    run_xfer("half_wait", 16'h0012, 3'd1, 1'b1, 4'b0010, 32'h5A5AC3C3, 32'h0, 5, 1'b0);
  endtask

  task automatic test_slverr_b2b();
    run_xfer("slverr_read", 16'h0300, 3'd2, 1'b0, 4'b0001, 32'h0, 32'h0BADF00D, 0, 1'b1);
    run_xfer("b2b_after_err", 16'h0304, 3'd2, 1'b0, 4'b0001, 32'h0, 32'h600DCAFE, 0, 1'b0);
  endtask

  task automatic test_unaligned();
    run_xfer("unaligned_word", 16'h0101, 3'd2, 1'b0, 4'b0001, 32'h0, 32'h11111111, 0, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = 16'h0420;
    bus.HSIZE  = 3'd2;
    bus.HWRITE = 1'b0;
    bus.HPROT  = 4'b0001;
    @(posedge HCLK);
    #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.PREADY = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    n_checks++;
    if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid pre: PSEL=%b PENABLE=%b expected 1/1", bus.PSEL, bus.PENABLE);
    end
    #2 HRESETn = 1'b0;
    #1;
    n_checks++;
    if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid async: PSEL=%b PENABLE=%b HREADYOUT=%b HRESP=%b expected 0/0/1/0",
               bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP);
    end
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    model_hrdata = '0;
    @(negedge HCLK);
    n_checks++;
    if (bus.HRDATA !== model_hrdata || bus.PSEL !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid after: HRDATA=%h PSEL=%b expected %h/0", bus.HRDATA, bus.PSEL, model_hrdata);
    end
    test_idle(1);
  endtask

  task automatic test_timeout();
    run_xfer("timeout", 16'h0040, 3'd2, 1'b0, 4'b0001, 32'h0, 32'h12345678, 20, 1'b0);
  endtask

  task automatic test_random(input int n);
    logic [2:0] sz;
    for (int i = 0; i < n; i++) begin
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      run_xfer("random", AW'($urandom), sz, 1'($urandom_range(0, 1)), 4'($urandom),
               $urandom, $urandom, $urandom_range(0, 4), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 2) == 0) test_idle($urandom_range(1, 2));
    end
  endtask

  initial begin
    bus.HSEL    = 1'b0;
    bus.HADDR   = '0;
    bus.HTRANS  = 2'b00;
    bus.HSIZE   = 3'd0;
    bus.HPROT   = 4'b0000;
    bus.HWRITE  = 1'b0;
    bus.HREADY  = 1'b1;
    bus.HWDATA  = '0;
    bus.PRDATA  = '0;
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    test_reset();
    test_word_read();
    test_byte_write();
    test_half_wait();
    test_idle(2);
    test_slverr_b2b();
    test_unaligned();
    test_idle(1);
    test_reset_mid_access();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_random(60);
    test_idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_to_apb_bridge.md
Name: ahb_to_apb_bridge

Overview:
- Single-clock AHB-Lite slave to APB4 master bridge, directly upstream of the APB peripherals in the AHB/APB subsystem.
- Converts each accepted AHB transfer into one APB SETUP/ACCESS sequence.
- Returns read data and the error status to AHB with registered HREADYOUT/HRESP.
- The APB side runs on the AHB clock (no PCLKEN).

Parameters:
ADDRWIDTH, 16, width of HADDR/PADDR
TIMEOUT_CYCLES, 255, max ACCESS-phase wait cycles before forced error (used only with APB_TIMEOUT_EN)

Ports:
HCLK  input  1  clock, drives AHB and APB sides
HRESETn  input  1  reset, asynchronous, active-low
HSEL  input  1  AHB slave select
HADDR  input  ADDRWIDTH  AHB address
HTRANS  input  2  AHB transfer type
HSIZE  input  3  AHB transfer size
HPROT  input  4  AHB protection
HWRITE  input  1  AHB write
HREADY  input  1  AHB bus ready (address-phase qualifier)
HWDATA  input  32  AHB write data
HREADYOUT  output  1  slave ready
HRDATA  output  32  AHB read data
HRESP  output  1  1 = ERROR
PADDR  output  ADDRWIDTH  APB address
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB write
PSTRB  output  4  APB byte strobes
PPROT  output  3  APB protection
PWDATA  output  32  APB write data
PRDATA  input  32  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB error

Behaviour:
- Clock and reset: one clock HCLK. Reset HRESETn is asynchronous, active-low. All outputs are registered.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PSTRB=0, PPROT=0, PWDATA=0, state=IDLE.
- Accept condition: HSEL & HTRANS[1] & HREADY & HREADYOUT=1. Accept is legal in IDLE and ERR2.
- On accept, register HADDR, HWRITE, HSIZE, HPROT.
- Illegal transfer: HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0. Go to ERR1 with no APB access.
- Legal read: go to SETUP. Legal write: go to WDATA.
- States:
  - IDLE: HREADYOUT=1, PSEL=0, PENABLE=0.
  - WDATA: HREADYOUT=0. Capture HWDATA into PWDATA at the end of the cycle, then go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0, then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Hold while PREADY=0.
    - PREADY & ~PSLVERR: capture PRDATA into HRDATA (reads only; writes leave HRDATA unchanged). Drop PSEL/PENABLE, go to IDLE with HREADYOUT=1 next cycle.
    - PREADY & PSLVERR: go to ERR1.
  - ERR1: HRESP=1, HREADYOUT=0, PSEL=0.
  - ERR2: HRESP=1, HREADYOUT=1. Next state is IDLE, or accept a new transfer if the accept condition holds.
- Latency, accept edge to HREADYOUT=1, with PREADY=1 immediately: read 3 cycles, write 4 cycles.
- PADDR, PWRITE, PSTRB and PPROT are stable from SETUP through the ACCESS completion.
- PSTRB:
  - Reads: 0000.
  - Byte: 0001<<HADDR[1:0].
  - Halfword: HADDR[1] ? 1100 : 0011.
  - Word: 1111.
- PPROT = {~HPROT[0], 1'b1, HPROT[1]}.
- HTRANS IDLE/BUSY or HSEL=0 while HREADY=1: no state change, OKAY response.
- Reset asserted mid-transfer: PSEL/PENABLE drop immediately (asynchronous), state=IDLE. The AHB transfer is abandoned.
- HRDATA holds the last read value until the next completed read.

Optional Feature:
APB_TIMEOUT_EN
- Defined: an 8+ bit counter (width clog2(TIMEOUT_CYCLES+1)) clears on entering ACCESS and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES: drop PSEL/PENABLE and go to ERR1.
- Undefined: no counter. ACCESS waits indefinitely for PREADY. TIMEOUT_CYCLES is unused.

Test Plan:
- Word read HADDR=0x0104, PREADY=1, PRDATA=0xDEADBEEF:
  - PADDR=0x0104, PSTRB=0000, PWRITE=0.
  - SETUP at +1 cycle, ACCESS at +2.
  - HREADYOUT=1 with HRDATA=0xDEADBEEF at +3, HRESP=0.
- Byte write HADDR=0x0203, HSIZE=0, HWDATA=0xAA000000:
  - PSTRB=1000, PWDATA=0xAA000000, PSEL rises at +2.
  - HREADYOUT=1 at +4.
- Halfword write at HADDR=0x0012 with PREADY held low 5 ACCESS cycles:
  - PSTRB=1100, PENABLE high for 6 cycles, addresses stable throughout.
  - OKAY completion.
- PSLVERR=1 on read completion: HRESP=1 for two cycles, HREADYOUT 0 then 1. A back-to-back read accepted in ERR2 starts SETUP next cycle.
- Unaligned word read HADDR=0x0101: PSEL never asserts, two-cycle ERROR response.
- Async reset mid-ACCESS: HRESETn low → PSEL=0, HREADYOUT=1 same cycle.
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY tied 0: ERROR after 4 ACCESS cycles.
